// File: rtl/vscale_dmem_arbiter.sv
// Round-robin arbiter that merges the core 0 and core 1 HASTI data-memory ports
// onto the shared SRAM data port, tagging each address with a per-core region prefix.
module vscale_dmem_arbiter #(
   parameter logic [1:0] REGION_0 = 2'b00,
   parameter logic [1:0] REGION_1 = 2'b00,
   localparam int HASTI_ADDR_WIDTH  = 32,
   localparam int HASTI_BUS_WIDTH   = 32,
   localparam int HASTI_SIZE_WIDTH  = 3,
   localparam int HASTI_BURST_WIDTH = 3,
   localparam int HASTI_PROT_WIDTH  = 4,
   localparam int HASTI_TRANS_WIDTH = 2
) (
   input  logic                          hclk,
   input  logic                          reset,
   input  logic [HASTI_ADDR_WIDTH-1:0]   m0_haddr,
   input  logic                          m0_hwrite,
   input  logic [HASTI_SIZE_WIDTH-1:0]   m0_hsize,
   input  logic [HASTI_BURST_WIDTH-1:0]  m0_hburst,
   input  logic                          m0_hmastlock,
   input  logic [HASTI_PROT_WIDTH-1:0]   m0_hprot,
   input  logic [HASTI_TRANS_WIDTH-1:0]  m0_htrans,
   input  logic [HASTI_BUS_WIDTH-1:0]    m0_hwdata,
   output logic [HASTI_BUS_WIDTH-1:0]    m0_hrdata,
   output logic                          m0_hready,
   output logic                          m0_hresp,
   input  logic [HASTI_ADDR_WIDTH-1:0]   m1_haddr,
   input  logic                          m1_hwrite,
   input  logic [HASTI_SIZE_WIDTH-1:0]   m1_hsize,
   input  logic [HASTI_BURST_WIDTH-1:0]  m1_hburst,
   input  logic                          m1_hmastlock,
   input  logic [HASTI_PROT_WIDTH-1:0]   m1_hprot,
   input  logic [HASTI_TRANS_WIDTH-1:0]  m1_htrans,
   input  logic [HASTI_BUS_WIDTH-1:0]    m1_hwdata,
   output logic [HASTI_BUS_WIDTH-1:0]    m1_hrdata,
   output logic                          m1_hready,
   output logic                          m1_hresp,
   output logic [HASTI_ADDR_WIDTH+1:0]   s_haddr,
   output logic                          s_hwrite,
   output logic [HASTI_SIZE_WIDTH-1:0]   s_hsize,
   output logic [HASTI_BURST_WIDTH-1:0]  s_hburst,
   output logic                          s_hmastlock,
   output logic [HASTI_PROT_WIDTH-1:0]   s_hprot,
   output logic [HASTI_TRANS_WIDTH-1:0]  s_htrans,
   output logic [HASTI_BUS_WIDTH-1:0]    s_hwdata,
   input  logic [HASTI_BUS_WIDTH-1:0]    s_hrdata,
   input  logic                          s_hready,
   input  logic                          s_hresp
);

   localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_IDLE   = 2'b00;
   localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_NONSEQ = 2'b10;

   typedef struct packed {
      logic [HASTI_ADDR_WIDTH-1:0]  addr;
      logic                         write;
      logic [HASTI_SIZE_WIDTH-1:0]  size;
      logic [HASTI_BURST_WIDTH-1:0] burst;
      logic                         mastlock;
      logic [HASTI_PROT_WIDTH-1:0]  prot;
   } aph_t;

   aph_t       live_aph [2];
   aph_t       pend_aph [2];
   aph_t       gnt_aph;
   logic [1:0] pend_valid;
   logic [1:0] live;
   logic [1:0] req;
   logic       rr;
   logic       gnt_valid;
   logic       gnt_id;
   logic       dp_valid;
   logic       dp_id;

   // A master's inputs only count while it is not already parked in its pending buffer.
   always_comb begin
      live_aph[0] = {m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hmastlock, m0_hprot};
      live_aph[1] = {m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hmastlock, m1_hprot};
      live[0]     = !pend_valid[0] && (m0_htrans == TRANS_NONSEQ);
      live[1]     = !pend_valid[1] && (m1_htrans == TRANS_NONSEQ);
      req         = pend_valid | live;
      gnt_valid   = (|req) && !reset;
      gnt_id      = (req[0] && req[1]) ? rr : req[1];
      gnt_aph     = '0;
      if (gnt_valid)
         gnt_aph = pend_valid[gnt_id] ? pend_aph[gnt_id] : live_aph[gnt_id];
   end

   always_comb begin
      s_haddr     = '0;
      s_htrans    = TRANS_IDLE;
      if (gnt_valid) begin
         s_haddr  = {(gnt_id ? REGION_1 : REGION_0), gnt_aph.addr};
         s_htrans = TRANS_NONSEQ;
      end
      s_hwrite    = gnt_aph.write;
      s_hsize     = gnt_aph.size;
      s_hburst    = gnt_aph.burst;
      s_hmastlock = gnt_aph.mastlock;
      s_hprot     = gnt_aph.prot;
   end

   // Nothing advances while the slave stalls, so the granted address phase stays put.
   always_ff @(posedge hclk or posedge reset) begin
      if (reset) begin
         pend_valid <= '0;
         pend_aph   <= '{default: '0};
         rr         <= 1'b0;
         dp_valid   <= 1'b0;
         dp_id      <= 1'b0;
      end else if (s_hready) begin
         dp_valid <= gnt_valid;
         dp_id    <= gnt_id;
         if (gnt_valid)
            rr <= ~gnt_id;
         for (int n = 0; n < 2; n++) begin
            if (gnt_valid && (gnt_id == 1'(n))) begin
               pend_valid[n] <= 1'b0;
            end else if (live[n]) begin
               pend_valid[n] <= 1'b1;
               pend_aph[n]   <= live_aph[n];
            end
         end
      end
   end

   always_comb begin
      s_hwdata = '0;
      if (dp_valid)
         s_hwdata = dp_id ? m1_hwdata : m0_hwdata;
      m0_hrdata = s_hrdata;
      m1_hrdata = s_hrdata;
      m0_hready = s_hready && !pend_valid[0];
      m1_hready = s_hready && !pend_valid[1];
      m0_hresp  = dp_valid && !dp_id && s_hresp;
      m1_hresp  = dp_valid && dp_id && s_hresp;
   end

endmodule

// File: tb/tb_vscale_dmem_arbiter.sv
// Directed bench for vscale_dmem_arbiter: reset, single read, collision,
// round-robin fairness, slave stall and region tagging.
module tb_vscale_dmem_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;

   logic        hclk = 1'b0;
   logic        reset;
   logic [31:0] m0_haddr, m1_haddr;
   logic        m0_hwrite, m1_hwrite;
   logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
   logic        m0_hmastlock, m1_hmastlock;
   logic [3:0]  m0_hprot, m1_hprot;
   logic [1:0]  m0_htrans, m1_htrans;
   logic [31:0] m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
   logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
   logic [33:0] s_haddr;
   logic        s_hwrite, s_hmastlock;
   logic [2:0]  s_hsize, s_hburst;
   logic [3:0]  s_hprot;
   logic [1:0]  s_htrans;
   logic [31:0] s_hwdata, s_hrdata;
   logic        s_hready, s_hresp;

   int          errors = 0;
   int          checks = 0;
   logic [33:0] exp_q[$];
   logic [31:0] dat_q[$];

   vscale_dmem_arbiter #(.REGION_0(2'b00), .REGION_1(2'b01)) dut (
      .hclk(hclk), .reset(reset),
      .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
      .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
      .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
      .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
      .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
      .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
      .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans),
      .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
   );

   // clock/reset block
   always #5 hclk = ~hclk;

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic settle();
      @(negedge hclk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // driver tasks
   task automatic drive(input int n, input logic [1:0] trans, input logic [31:0] addr, input logic wr);
      if (n == 0) begin
         m0_htrans = trans; m0_haddr = addr; m0_hwrite = wr;
      end else begin
         m1_htrans = trans; m1_haddr = addr; m1_hwrite = wr;
      end
   endtask

   task automatic idle_all();
      drive(0, IDLE, 32'h0, 1'b0);
      drive(1, IDLE, 32'h0, 1'b0);
   endtask

   // scoreboard
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_addr(input int n, input logic [31:0] a);
      exp_q.push_back({(n == 0) ? 2'b00 : 2'b01, a});
   endtask

   task automatic check_addr(input string tag);
      logic [33:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%0h expected=<empty queue>", tag, s_haddr);
      end else begin
         e = exp_q.pop_front();
         chk(tag, s_haddr, e);
         chk({tag, "_trans"}, s_htrans, NONSEQ);
      end
   endtask

   task automatic check_data(input string tag);
      logic [31:0] e;
      if (dat_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%0h expected=<empty queue>", tag, s_hwdata);
      end else begin
         e = dat_q.pop_front();
         chk(tag, s_hwdata, e);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] wa;
      logic [31:0] wb;
      int c0, c1, z0, z1, worst;
      logic r0, r1;

      reset = 1'b1;
      idle_all();
      m0_hsize = 3'd2; m1_hsize = 3'd2; m0_hburst = 3'd0; m1_hburst = 3'd0;
      m0_hmastlock = 1'b0; m1_hmastlock = 1'b0; m0_hprot = 4'h3; m1_hprot = 4'h3;
      m0_hwdata = '0; m1_hwdata = '0;
      s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;
      step();
      settle();
      chk("rst_htrans", s_htrans, IDLE);
      chk("rst_haddr", s_haddr, 34'h0);
      chk("rst_m0_hready", m0_hready, 1'b1);
      chk("rst_m1_hready", m1_hready, 1'b1);
      step();
      reset = 1'b0;

      // single read from m0
      drive(0, NONSEQ, 32'h10, 1'b0);
      expect_addr(0, 32'h10);
      settle();
      check_addr("read_addr");
      step();
      idle_all();
      rd = $urandom;
      s_hrdata = rd;
      settle();
      chk("read_m0_hrdata", m0_hrdata, {32'h0, rd});
      chk("read_m1_hrdata", m1_hrdata, {32'h0, rd});
      chk("read_m0_hready", m0_hready, 1'b1);
      chk("read_m1_hready", m1_hready, 1'b1);
      chk("read_idle", s_htrans, IDLE);
      step();

      // reset asserted during a write data phase
      drive(0, NONSEQ, 32'h20, 1'b1);
      expect_addr(0, 32'h20);
      settle();
      check_addr("rw_addr");
      step();
      wa = $urandom;
      m0_hwdata = wa;
      dat_q.push_back(wa);
      drive(0, NONSEQ, 32'h24, 1'b1);
      s_hresp = 1'b1;
      settle();
      check_data("rw_wdata");
      chk("rw_hresp", m0_hresp, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_htrans", s_htrans, IDLE);
      chk("mid_rst_haddr", s_haddr, 34'h0);
      chk("mid_rst_hwdata", s_hwdata, 32'h0);
      chk("mid_rst_m0_hready", m0_hready, 1'b1);
      chk("mid_rst_m1_hready", m1_hready, 1'b1);
      chk("mid_rst_hresp", m0_hresp, 1'b0);
      step();
      reset = 1'b0;
      s_hresp = 1'b0;
      idle_all();
      drive(1, NONSEQ, 32'h30, 1'b0);
      expect_addr(1, 32'h30);
      settle();
      check_addr("post_rst_m1_addr");
      step();
      idle_all();

      // collision right after reset: m0 wins, m1 waits one cycle
      do_reset();
      drive(0, NONSEQ, 32'h4, 1'b1);
      drive(1, NONSEQ, 32'h8, 1'b1);
      expect_addr(0, 32'h4);
      expect_addr(1, 32'h8);
      settle();
      check_addr("coll_t_addr");
      step();
      drive(0, IDLE, 32'h0, 1'b0);
      wa = $urandom;
      wb = $urandom;
      m0_hwdata = wa;
      m1_hwdata = wb;
      dat_q.push_back(wa);
      dat_q.push_back(wb);
      settle();
      check_addr("coll_t1_addr");
      check_data("coll_t1_wdata");
      chk("coll_t1_m1_hready", m1_hready, 1'b0);
      chk("coll_t1_m0_hready", m0_hready, 1'b1);
      step();
      idle_all();
      settle();
      check_data("coll_t2_wdata");
      chk("coll_t2_m1_hready", m1_hready, 1'b1);
      chk("coll_t2_idle", s_htrans, IDLE);
      step();

      // fairness: both masters request every cycle, advancing when accepted
      do_reset();
      c0 = 0; c1 = 0; z0 = 0; z1 = 0; worst = 0;
      r0 = 1'b0; r1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (r0) c0++;
         if (r1) c1++;
         drive(0, NONSEQ, 32'h100 + 32'(4 * c0), 1'b0);
         drive(1, NONSEQ, 32'h200 + 32'(4 * c1), 1'b0);
         if (i % 2 == 0) expect_addr(0, 32'h100 + 32'(4 * (i / 2)));
         else            expect_addr(1, 32'h200 + 32'(4 * (i / 2)));
         settle();
         check_addr("fair_addr");
         r0 = m0_hready;
         r1 = m1_hready;
         z0 = r0 ? 0 : z0 + 1;
         z1 = r1 ? 0 : z1 + 1;
         if (z0 > worst) worst = z0;
         if (z1 > worst) worst = z1;
         step();
      end
      idle_all();
      chk("fair_worst_wait", 64'(worst), 64'd1);

      // slave stall with m1 parked in its buffer
      do_reset();
      drive(0, NONSEQ, 32'h40, 1'b0);
      drive(1, NONSEQ, 32'h44, 1'b0);
      expect_addr(0, 32'h40);
      settle();
      check_addr("stall_t_addr");
      step();
      drive(0, IDLE, 32'h0, 1'b0);
      s_hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_addr(1, 32'h44);
         settle();
         check_addr("stall_addr");
         chk("stall_m0_hready", m0_hready, 1'b0);
         chk("stall_m1_hready", m1_hready, 1'b0);
         step();
      end
      s_hready = 1'b1;
      expect_addr(1, 32'h44);
      settle();
      check_addr("stall_release_addr");
      chk("stall_release_m1_hready", m1_hready, 1'b0);
      step();
      idle_all();
      s_hresp = 1'b1;
      settle();
      chk("stall_done_idle", s_htrans, IDLE);
      chk("stall_done_m1_hready", m1_hready, 1'b1);
      chk("stall_m1_hresp", m1_hresp, 1'b1);
      chk("stall_m0_hresp", m0_hresp, 1'b0);
      step();
      s_hresp = 1'b0;

      // region prefixes
      drive(0, NONSEQ, 32'h8, 1'b0);
      settle();
      chk("region_m0", s_haddr, 34'h0_0000_0008);
      step();
      idle_all();
      drive(1, NONSEQ, 32'h8, 1'b0);
      settle();
      chk("region_m1", s_haddr, 34'h1_0000_0008);
      step();
      idle_all();
      step();

      chk("queue_drained", 64'(exp_q.size() + dat_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vscale_dmem_arbiter.md
# vscale_dmem_arbiter

- Two-master HASTI arbiter that merges the data-memory ports of core 0 and core 1 onto the single shared data port (p0) of the dual-port HASTI SRAM.
- Tags each granted address with a per-master 2-bit region prefix to form the widened p0 address.
- Uses round-robin arbitration, buffers the losing address phase, and stalls the loser via its hready.
- Routes the data phase so each core sees standard AHB-lite pipelined behaviour.

## Interface
Parameters:
- REGION_0, 2'b00, prefix prepended to master 0 addresses
- REGION_1, 2'b00, prefix prepended to master 1 addresses

Ports:
- hclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mN_haddr  in  HASTI_ADDR_WIDTH  master N address (N = 0, 1; all mN_* ports repeat per master)
- mN_hwrite  in  1  write
- mN_hsize  in  HASTI_SIZE_WIDTH  size
- mN_hburst  in  HASTI_BURST_WIDTH  burst
- mN_hmastlock  in  1  lock, passed through only
- mN_hprot  in  HASTI_PROT_WIDTH  protection
- mN_htrans  in  HASTI_TRANS_WIDTH  transfer type
- mN_hwdata  in  HASTI_BUS_WIDTH  write data, driven in data phase
- mN_hrdata  out  HASTI_BUS_WIDTH  read data
- mN_hready  out  1  ready to master N
- mN_hresp  out  1  response to master N
- s_haddr  out  2+HASTI_ADDR_WIDTH  {REGION_g, granted address}
- s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans  out  (widths as above)  granted address phase
- s_hwdata  out  HASTI_BUS_WIDTH  data-phase owner write data
- s_hrdata  in  HASTI_BUS_WIDTH  slave read data
- s_hready  in  1  slave ready
- s_hresp  in  1  slave response

## Operation
**Request qualification**
- A master N request is htrans==NONSEQ sampled in a cycle where mN_hready==1.
- IDLE, BUSY and SEQ are not requests.
- A master's inputs are ignored while its hready==0.

**Pending buffer, per master**
- Fields: buf_valid, addr, write, size, burst, mastlock, prot.
- A master is requesting if buf_valid==1 or it presents a live request.

**Round-robin**
- rr pointer names the priority master.
- With one requester, that master is granted. With two, rr wins.
- On any grant, rr <= other master.
- Reset value: rr = 0.

**Address phase**
- The granted master's fields drive s_*: from the buffer if buf_valid, else live.
- With no grant: s_htrans=IDLE, other s_* = 0.
- A live, non-granted request is captured into that master's buffer (buf_valid<=1).
- A granted buffer clears (buf_valid<=0).

**Data phase**
- Registers dp_valid/dp_id are loaded with grant valid/id.
- s_hwdata = mN_hwdata of dp_id when dp_valid, else 0.
- s_hrdata is broadcast to both mN_hrdata.
- s_hresp goes to the dp_id master; the other master sees OKAY.

**Ready**
- mN_hready = s_hready && !buf_valid_N.

**s_hready==0**
- Buffers, rr and dp_* hold.
- The grant decision is unchanged: the buffer or the stalled live master holds its fields, so s_* are stable.

**Reset (asynchronous, any time, including mid-transfer)**
- buf_valid=0, rr=0, dp_valid=0.
- Outputs: s_htrans=IDLE, s_haddr=0, s_hwdata=0, mN_hready=s_hready, mN_hresp=OKAY.
- An in-flight transfer is dropped.

## Timing
- Uncontended: address at cycle t reaches s_* in the same cycle t (combinational). Data phase and hready at t+1 (zero added latency).
- Contended loser:
  - Buffered at t.
  - Issued at t+1 (rr now favours it), using mN_hwdata it holds from t+1.
  - Data phase completes at t+2, adding exactly 1 stall cycle.
- Worst-case wait with s_hready==1 is 1 cycle. Fairness is guaranteed because the buffer is issued before the other master's next live request.
- All state updates only on hclk edges where s_hready==1 (reset excepted).
- Simultaneous buffer issue and other master's live request: the buffer has rr priority, and the live request is captured to its own buffer.

## Test plan
- **Reset:** assert reset mid-write with s_hready=1.
  - Immediately: s_htrans=0 and m0_hready=m1_hready=1.
  - After release: the next m1 request is granted in the same cycle.
- **Single read:** m0 NONSEQ read 0x10 at t.
  - t: s_haddr=0x10, s_htrans=2'b10.
  - t+1: m0_hrdata=s_hrdata, m0_hready=1; m1_hready stays 1.
- **Collision after reset:** both NONSEQ write at t (m0 0x4, m1 0x8).
  - t: s_haddr=0x4.
  - t+1: s_haddr=0x8, s_hwdata=m0_hwdata, m1_hready=0.
  - t+2: s_hwdata=m1_hwdata, m1_hready=1.
- **Fairness:** both masters request continuously for 10 cycles.
  - Grants alternate 0,1,0,1.
  - No master waits more than 1 cycle.
- **Slave stall:** hold s_hready=0 for 3 cycles with m1 buffered.
  - s_haddr/s_htrans stable; both hready=0.
  - m1 issues on the first cycle s_hready=1.
- **Region:** REGION_1=2'b01, m1 read 0x8 -> s_haddr=34'h1_0000_0008; m0 0x8 -> 34'h0_0000_0008.
